// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the hard-wired zero register and
// the writeback entry carried through the long-latency result buffer.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    localparam logic [REG_ADDR_W-1:0] R_ZERO = 4'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small FIFO holding long-latency writeback results until the register file
// write port is free. DEPTH must be a power of two so the pointers wrap freely.
module wb_skid_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reset empties the FIFO, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and long-latency results onto the register
// file write port and tracks busy registers. Macro WB_BYPASS_EN adds forwarding.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_wr_en,
    input  logic [REG_ADDR_W-1:0] alu_wr_reg,
    input  logic [DATA_W-1:0]     alu_wr_data,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_reg,
    input  logic [DATA_W-1:0]     lu_data,
    input  logic                  issue_lu,
    input  logic [REG_ADDR_W-1:0] issue_reg,
    input  logic [REG_ADDR_W-1:0] chk_reg_a,
    input  logic [REG_ADDR_W-1:0] chk_reg_b,
    output logic                  hazard,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data
`ifdef WB_BYPASS_EN
    ,
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit,
    output logic [DATA_W-1:0]     fwd_data_a,
    output logic [DATA_W-1:0]     fwd_data_b
`endif
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;

    wb_entry_t           lu_entry;
    wb_entry_t           head;
    wb_entry_t           sel_entry;
    logic                sel_valid;
    logic                sel_is_lu;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                lu_fire;
    logic                port_hit_a;
    logic                port_hit_b;
    logic [NUM_REGS-1:0] busy;

    assign lu_entry = '{rd: lu_reg, data: lu_data};
    assign lu_ready = !fifo_full;
    assign lu_fire  = lu_valid && lu_ready;

    wb_skid_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (lu_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // ALU first, then the oldest buffered result, then a direct bypass of the offer.
    always_comb begin
        sel_entry = '{rd: alu_wr_reg, data: alu_wr_data};
        sel_valid = 1'b0;
        sel_is_lu = 1'b0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (alu_wr_en) begin
            sel_valid = 1'b1;
            fifo_push = lu_fire;
        end else if (!fifo_empty) begin
            sel_entry = head;
            sel_valid = 1'b1;
            sel_is_lu = 1'b1;
            fifo_pop  = 1'b1;
            fifo_push = lu_fire;
        end else if (lu_fire) begin
            sel_entry = lu_entry;
            sel_valid = 1'b1;
            sel_is_lu = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            reg_write <= sel_valid && (sel_entry.rd != R_ZERO);
            if (sel_valid) begin
                write_reg  <= sel_entry.rd;
                write_data <= sel_entry.data;
            end
        end
    end

    // Busy clears as the result is loaded onto the port; a same-cycle issue re-sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (sel_valid && sel_is_lu) busy[sel_entry.rd] <= 1'b0;
            if (issue_lu && (issue_reg != R_ZERO)) busy[issue_reg] <= 1'b1;
        end
    end

    assign port_hit_a = reg_write && (write_reg != R_ZERO) && (write_reg == chk_reg_a);
    assign port_hit_b = reg_write && (write_reg != R_ZERO) && (write_reg == chk_reg_b);

`ifdef WB_BYPASS_EN
    assign fwd_a_hit  = port_hit_a;
    assign fwd_b_hit  = port_hit_b;
    assign fwd_data_a = write_data;
    assign fwd_data_b = write_data;
    assign hazard     = busy[chk_reg_a] | busy[chk_reg_b];
`else
    // The register file samples reads on the write edge, so an in-flight write must stall.
    assign hazard     = busy[chk_reg_a] | busy[chk_reg_b] | port_hit_a | port_hit_b;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: ALU path, bypass, buffering,
// scoreboard, r0 filtering and asynchronous reset.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_wr_en;
    logic [3:0]  alu_wr_reg;
    logic [15:0] alu_wr_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [3:0]  lu_reg;
    logic [15:0] lu_data;
    logic        issue_lu;
    logic [3:0]  issue_reg;
    logic [3:0]  chk_reg_a;
    logic [3:0]  chk_reg_b;
    logic        hazard;
    logic        reg_write;
    logic [3:0]  write_reg;
    logic [15:0] write_data;
`ifdef WB_BYPASS_EN
    logic        fwd_a_hit;
    logic        fwd_b_hit;
    logic [15:0] fwd_data_a;
    logic [15:0] fwd_data_b;
`endif

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_wr_en   (alu_wr_en),
        .alu_wr_reg  (alu_wr_reg),
        .alu_wr_data (alu_wr_data),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_reg      (lu_reg),
        .lu_data     (lu_data),
        .issue_lu    (issue_lu),
        .issue_reg   (issue_reg),
        .chk_reg_a   (chk_reg_a),
        .chk_reg_b   (chk_reg_b),
        .hazard      (hazard),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data)
`ifdef WB_BYPASS_EN
        ,
        .fwd_a_hit   (fwd_a_hit),
        .fwd_b_hit   (fwd_b_hit),
        .fwd_data_a  (fwd_data_a),
        .fwd_data_b  (fwd_data_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic a_en, input logic [3:0] a_reg, input logic [15:0] a_data,
                                 input logic l_vld, input logic [3:0] l_reg, input logic [15:0] l_data,
                                 input logic iss, input logic [3:0] i_reg);
        alu_wr_en   = a_en;
        alu_wr_reg  = a_reg;
        alu_wr_data = a_data;
        lu_valid    = l_vld;
        lu_reg      = l_reg;
        lu_data     = l_data;
        issue_lu    = iss;
        issue_reg   = i_reg;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPort(input string tag, input logic we, input logic [3:0] rd, input logic [15:0] d);
        checkOutput({tag, "_we"}, 32'(reg_write), 32'(we));
        checkOutput({tag, "_reg"}, 32'(write_reg), 32'(rd));
        checkOutput({tag, "_data"}, 32'(write_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1;
        chk_reg_a = 4'd0;
        chk_reg_b = 4'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        checkPort("reset", 0, 0, 16'h0000);
        checkOutput("reset_ready", 32'(lu_ready), 1);
        checkOutput("reset_hazard", 32'(hazard), 0);
        step();
        rst = 1'b0;

        $display("[TB] ALU-only stream");
        applyStimulus(1, 3, 16'h1234, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkPort("alu", 1, 3, 16'h1234);
        chk_reg_b = 4'd3;
        #1;
`ifdef WB_BYPASS_EN
        checkOutput("alu_port_hazard", 32'(hazard), 0);
        checkOutput("alu_fwd_b_hit", 32'(fwd_b_hit), 1);
        checkOutput("alu_fwd_b_data", 32'(fwd_data_b), 32'h1234);
`else
        checkOutput("alu_port_hazard", 32'(hazard), 1);
`endif
        step();
        checkPort("alu_idle", 0, 3, 16'h1234);
        checkOutput("alu_idle_hazard", 32'(hazard), 0);
        chk_reg_b = 4'd0;

        $display("[TB] Bypass");
        applyStimulus(0, 0, 0, 1, 5, 16'hBEEF, 0, 0);
        #1;
        checkOutput("byp_ready", 32'(lu_ready), 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkPort("byp", 1, 5, 16'hBEEF);
        step();
        checkOutput("byp_idle_we", 32'(reg_write), 0);

        $display("[TB] Conflict and fill");
        applyStimulus(1, 1, 16'h000A, 1, 6, 16'h0001, 0, 0);
        #1;
        checkOutput("fill_ready0", 32'(lu_ready), 1);
        step();
        checkPort("fill_alu1", 1, 1, 16'h000A);
        applyStimulus(1, 2, 16'h000B, 1, 7, 16'h0002, 0, 0);
        #1;
        checkOutput("fill_ready1", 32'(lu_ready), 1);
        step();
        checkPort("fill_alu2", 1, 2, 16'h000B);
        applyStimulus(1, 10, 16'h000C, 1, 8, 16'h0003, 0, 0);
        #1;
        checkOutput("fill_ready2", 32'(lu_ready), 0);
        step();
        checkPort("fill_alu3", 1, 10, 16'h000C);
        applyStimulus(1, 11, 16'h000D, 1, 8, 16'h0003, 0, 0);
        #1;
        checkOutput("fill_ready3", 32'(lu_ready), 0);
        step();
        checkPort("fill_alu4", 1, 11, 16'h000D);
        applyStimulus(0, 0, 0, 1, 8, 16'h0003, 0, 0);
        #1;
        checkOutput("fill_ready_popping", 32'(lu_ready), 0);
        step();
        checkPort("drain_r6", 1, 6, 16'h0001);
        checkOutput("drain_ready", 32'(lu_ready), 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkPort("drain_r7", 1, 7, 16'h0002);
        step();
        checkPort("drain_r8", 1, 8, 16'h0003);
        step();
        checkOutput("drain_idle_we", 32'(reg_write), 0);

        $display("[TB] Scoreboard");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        chk_reg_a = 4'd4;
        #1;
        checkOutput("sb_busy0", 32'(hazard), 1);
        step();
        checkOutput("sb_busy1", 32'(hazard), 1);
        applyStimulus(0, 0, 0, 1, 4, 16'h4444, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkPort("sb_result", 1, 4, 16'h4444);
`ifdef WB_BYPASS_EN
        checkOutput("sb_on_port", 32'(hazard), 0);
        checkOutput("sb_fwd_a_hit", 32'(fwd_a_hit), 1);
`else
        checkOutput("sb_on_port", 32'(hazard), 1);
`endif
        step();
        checkOutput("sb_after", 32'(hazard), 0);
        chk_reg_a = 4'd0;

        $display("[TB] r0 filter");
        applyStimulus(1, 0, 16'hFFFF, 0, 0, 0, 1, 0);
        step();
        applyStimulus(0, 0, 0, 1, 0, 16'h7777, 0, 0);
        checkOutput("r0_alu_we", 32'(reg_write), 0);
        #1;
        checkOutput("r0_hazard", 32'(hazard), 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_lu_we", 32'(reg_write), 0);
        checkOutput("r0_hazard2", 32'(hazard), 0);

        $display("[TB] Async reset");
        applyStimulus(1, 14, 16'h000E, 1, 12, 16'h0055, 1, 9);
        step();
        applyStimulus(1, 15, 16'h000F, 1, 13, 16'h0066, 0, 0);
        step();
        applyStimulus(1, 1, 16'h0001, 0, 0, 0, 0, 0);
        chk_reg_a = 4'd9;
        #1;
        checkOutput("pre_rst_hazard", 32'(hazard), 1);
        checkOutput("pre_rst_ready", 32'(lu_ready), 0);
        checkOutput("pre_rst_we", 32'(reg_write), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_we", 32'(reg_write), 0);
        checkOutput("rst_ready", 32'(lu_ready), 1);
        checkOutput("rst_hazard", 32'(hazard), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post_rst_we", 32'(reg_write), 0);
            checkOutput("post_rst_hazard", 32'(hazard), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
